mult32_shift_seq: RTL and testbench
===================================

// Module: mult32_shift_seq
// PURPOSE
//  Iterative 32x32 -> 64-bit unsigned shift-and-add multiplier.
//  - Sits directly downstream of the 32-bit barrel shifter and consumes its output.
//  - Each iteration does a conditional add of the multiplicand into HI.
//  - It then shifts {carry,HI,LO} right by 1 using two SHIFT32 instances (LnR=0, S=1).
//  - Feeds the ALU's MUL result path, which reads HI and LO.
// PARAMETERS
//  WIDTH   32  operand width; must equal `DATA_WIDTH (shifter instances are 32-bit)
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  CLK    in   1      clock; all state changes on the rising edge
//  RST    in   1      synchronous reset, active-high
//  START  in   1      request a multiply; sampled only in IDLE or DONE
//  A      in   WIDTH  multiplicand (unsigned); latched when START is accepted
//  B      in   WIDTH  multiplier (unsigned); latched when START is accepted
//  BUSY   out  1      high while in RUN
//  DONE   out  1      one-cycle pulse; product valid on HI/LO
//  HI     out  WIDTH  upper half of product (working register)
//  LO     out  WIDTH  lower half of product (working register)
// BEHAVIOUR
//  - Reset: state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, internal MCAND=0, CNT=0.
//  - States: IDLE, RUN, DONE. State is registered; BUSY and DONE are decoded from state.
//  - IDLE/DONE -> RUN on START=1:
//      MCAND<=A, HI<=0, LO<=B, CNT<=0.
//  - IDLE/DONE -> IDLE on START=0. HI/LO hold their last values.
//  - RUN, one iteration per edge:
//      sum[WIDTH:0] = LO[0] ? {1'b0,HI}+{1'b0,MCAND} : {1'b0,HI}
//      HI <= SHIFT32_R(sum[WIDTH-1:0],1) with bit WIDTH-1 replaced by sum[WIDTH]
//      LO <= SHIFT32_R(LO,1) with bit WIDTH-1 replaced by sum[0]
//      CNT <= CNT+1
//  - RUN -> DONE on the edge where CNT==WIDTH-1, i.e. the 32nd iteration.
//  - DONE -> IDLE after one cycle, unless START=1, in which case DONE -> RUN.
//  - Latency: START sampled at edge k => BUSY high for cycles k+1..k+32.
//    DONE is high in the cycle after edge k+32, exactly 33 edges after START.
//  - Throughput: a back-to-back START presented during the DONE cycle is accepted
//    with no idle gap.
//  - START during RUN is ignored: no restart, operands are not re-latched,
//    and the result is unaffected.
//  - A and B may change freely after acceptance; only the latched copies are used.
//  - HI/LO are intermediate values while BUSY=1. They are architecturally valid
//    from the DONE cycle until the next accepted START.
//  - Zero operands still take the full 32 iterations; there is no early termination.
//  - The carry out of the add is never lost; the full 64-bit product is exact
//    for all inputs.
//  - RST=1 in any state, including mid-RUN, forces the reset values on the next edge.
//    Any in-flight operation is discarded and DONE does not pulse.
//  - RST has priority over START on the same edge.
// TESTING
//  1. A=3, B=5, START 1 cycle -> BUSY for 32 cycles; DONE pulse at edge+33;
//     HI=0x00000000, LO=0x0000000F.
//  2. A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (exercises add carry).
//  3. A=0x80000000, B=0x00000002 -> HI=0x00000001, LO=0x00000000.
//     A=0, B=0x12345678 -> HI=LO=0, still 33-edge latency.
//  4. START with A=7, B=6; at RUN cycle 10 pulse START with A=9, B=9 -> ignored;
//     result HI=0, LO=0x2A; DONE at the original time.
//  5. Assert RST at RUN cycle 15 -> next cycle BUSY=0, HI=LO=0, no DONE pulse.
//     New START with A=2, B=2 -> LO=4.
//  6. Hold START=1 through DONE with new A=0x10000, B=0x10000 -> RUN re-entered
//     directly from DONE; result HI=0x00000001, LO=0.
//  7. Random compare of 1000 operand pairs against a 64-bit reference model.

Source files
------------

// File: rtl/mult32_shift_seq.sv
// mult32_shift_seq: iterative 32x32 -> 64-bit unsigned shift-and-add multiplier.
// One conditional add plus a one-bit right shift of {carry,HI,LO} per clock;
// 32 iterations per product. HI/LO are the working registers and hold the
// product from the DONE cycle until the next accepted START.
module mult32_shift_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_shift;
  logic [WIDTH-1:0] lo_shift;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // Barrel-shift stage (SHIFT32 behaviour): lnr=1 shifts left, lnr=0 shifts
  // right, zero fill in both directions. Used twice, right by one, below.
  function automatic logic [WIDTH-1:0] shift32(
    input logic [WIDTH-1:0] d,
    input logic [SH_W-1:0]  s,
    input logic             lnr
  );
    return lnr ? (d << s) : (d >> s);
  endfunction

  // A new operation is only accepted when no multiply is in flight.
  assign accept = START && ((state == S_IDLE) || (state == S_DONE));

  // Conditional add keeps the carry in bit WIDTH so the product stays exact.
  assign sum = LO[0] ? ({1'b0, HI} + {1'b0, mcand}) : {1'b0, HI};

  assign hi_shift = shift32(sum[WIDTH-1:0], SH_W'(1), 1'b0);
  assign lo_shift = shift32(LO, SH_W'(1), 1'b0);

  // The shifters zero-fill the MSB; the carry enters HI and sum[0] enters LO.
  assign hi_next = hi_shift | {sum[WIDTH], {(WIDTH-1){1'b0}}};
  assign lo_next = lo_shift | {sum[0],     {(WIDTH-1){1'b0}}};

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);

  // Next-state decode: IDLE/DONE start on START, RUN ends after the last iteration.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:  state_next = START ? S_RUN : S_IDLE;
      S_RUN:   state_next = (cnt == LAST_ITER) ? S_DONE : S_RUN;
      S_DONE:  state_next = START ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over START.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch operands on accept, one shift-add iteration per RUN cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand <= '0;
      HI    <= '0;
      LO    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= A;
      HI    <= '0;
      LO    <= B;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      HI  <= hi_next;
      LO  <= lo_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult32_shift_seq.sv
// tb_mult32_shift_seq: directed and random checks of mult32_shift_seq against
// a 64-bit arithmetic reference, including latency, START-during-RUN,
// mid-run reset and back-to-back operation.
module tb_mult32_shift_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors    = 0;
  int miscompares = 0;

  mult32_shift_seq dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .A    (A),
    .B    (B),
    .BUSY (BUSY),
    .DONE (DONE),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 CLK = ~CLK;

  // Reference product: plain 64-bit unsigned multiplication.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present START with operands for exactly one edge; operands are then
  // scrambled so only the latched copies can produce the right answer.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    START = 1'b1;
    A     = a;
    B     = b;
    @(negedge CLK);
    START = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Count BUSY cycles (bounded), then expect the DONE pulse and the product.
  task automatic finish(input int already, input logic [63:0] exp, input string tag);
    int busy_cycles = already;
    while (BUSY && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge CLK);
    end
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd32);
    check({tag, "_done"},        64'(DONE),        64'd1);
    check({tag, "_product"},     {HI, LO},         exp);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    @(negedge CLK);
    launch(a, b);
    finish(0, exp, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_seen;

    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_hilo", {HI, LO},  64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic product and latency.
    do_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "t1_3x5");
    @(negedge CLK);
    check("t1_idle_after_done", 64'({BUSY, DONE}), 64'd0);
    check("t1_hold_hilo",       {HI, LO},          64'h0000_0000_0000_000F);

    // Carry out of the add, MSB multiplicand, zero multiplicand.
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "t2_max");
    do_mul(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, "t3_msb");
    do_mul(32'h0000_0000, 32'h1234_5678, 64'h0,                   "t3_zero");

    // START during RUN is ignored.
    @(negedge CLK);
    launch(32'd7, 32'd6);
    repeat (10) @(negedge CLK);
    START = 1'b1;
    A     = 32'd9;
    B     = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    finish(11, 64'h2A, "t4_start_in_run");

    // Reset mid-run (with START also high) discards the operation.
    @(negedge CLK);
    launch(32'd100, 32'd200);
    repeat (14) @(negedge CLK);
    check("t5_busy_before_rst", 64'(BUSY), 64'd1);
    RST   = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    check("t5_busy_after_rst", 64'(BUSY), 64'd0);
    check("t5_hilo_after_rst", {HI, LO},  64'd0);
    done_seen = 0;
    repeat (40) begin
      if (DONE) done_seen++;
      @(negedge CLK);
    end
    check("t5_no_done_pulse", 64'(done_seen), 64'd0);
    do_mul(32'd2, 32'd2, 64'd4, "t5_after_rst");

    // Back-to-back: START presented in the DONE cycle re-enters RUN directly.
    do_mul(32'd11, 32'd13, 64'd143, "t6_first");
    launch(32'h0001_0000, 32'h0001_0000);
    check("t6_rerun_busy", 64'(BUSY), 64'd1);
    finish(0, 64'h0000_0001_0000_0000, "t6_second");

    // Random operand pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = (i % 16 == 0) ? 32'hFFFF_FFFF : 32'h0;
      if (i % 12 == 0) rb = 32'hFFFF_FFFF;
      @(negedge CLK);
      launch(ra, rb);
      finish(0, ref_mul(ra, rb), $sformatf("rand_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
